// File: rtl/imem_fetch_responder.sv
// imem_fetch_responder: multi-cycle instruction-memory responder for the
// fetch stage. One word-aligned fetch in flight at a time, answered after
// LAT cycles with a one-cycle done pulse. A side write port loads the program.
//
// Optional feature: define IMEM_ALIGN_CHECK_EN to answer odd-address fetches
// on the next cycle with err=1 and data_out=0 instead of reading the array.
// Without it, addr[0] is ignored and err is tied low.
//
// cnt_q holds the number of cycles left until the done cycle. A fetch
// accepted in cycle T spends cycles T+1..T+LAT-1 in BUSY. The array is read
// on the edge that ends cycle T+LAT-1, so done rises in cycle T+LAT. With
// LAT=1 the array is read on the accepting edge itself and BUSY is skipped.

module imem_fetch_responder #(
    parameter int WORDS_LOG2 = 9,
    parameter int LAT        = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic [15:0] addr,
    input  logic        flush,
    input  logic        wr_en,
    input  logic [15:0] wr_addr,
    input  logic [15:0] wr_data,
    output logic        stall,
    output logic        done,
    output logic [15:0] data_out,
    output logic        err
);

    localparam int       DEPTH  = 2 ** WORDS_LOG2;
    localparam logic [3:0] LAT_M1 = 4'(LAT - 1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    state_e                state_q;
    logic [3:0]            cnt_q;
    logic [WORDS_LOG2-1:0] idx_q;
    logic [15:0]           data_q;
    logic                  done_q;
    logic [15:0]           mem [DEPTH];

    logic                  accept;
    logic                  misalign;
    logic [WORDS_LOG2-1:0] req_idx;
    logic [WORDS_LOG2-1:0] wr_idx;
    logic                  unused_bits;

    // Upper address bits alias onto the array; bit 0 is not a word bit.
    assign req_idx     = addr[WORDS_LOG2:1];
    assign wr_idx      = wr_addr[WORDS_LOG2:1];
    assign unused_bits = ^{addr[15:WORDS_LOG2+1], addr[0],
                           wr_addr[15:WORDS_LOG2+1], wr_addr[0]};

`ifdef IMEM_ALIGN_CHECK_EN
    logic err_q;
    assign misalign = addr[0];
`else
    assign misalign = 1'b0;
`endif

    // A request is taken only from IDLE and only when not flushed.
    assign accept = (state_q == IDLE) & req & ~flush;

    // Stall is forced low during reset so the fetch stage is never held.
    assign stall    = rst & ((state_q == BUSY) | accept);
    assign done     = done_q & ~flush;
    assign data_out = data_q;
`ifdef IMEM_ALIGN_CHECK_EN
    assign err      = err_q & ~flush;
`else
    assign err      = 1'b0;
`endif

    // Program-load write port, independent of the fetch state machine.
    // NOTE: the array has no reset; resetting it would turn a RAM into flops.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

    // Fetch FSM with registered response outputs.
    // NOTE: state uses non-blocking assignments so every flop samples
    // pre-edge values; this is also what makes a same-edge write invisible
    // to the read.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            idx_q   <= '0;
            data_q  <= 16'h0000;
            done_q  <= 1'b0;
`ifdef IMEM_ALIGN_CHECK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
`ifdef IMEM_ALIGN_CHECK_EN
            err_q  <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        if (misalign) begin
                            // Answered immediately without touching the array.
                            data_q <= 16'h0000;
                            done_q <= 1'b1;
`ifdef IMEM_ALIGN_CHECK_EN
                            err_q  <= 1'b1;
`endif
                        end else if (LAT_M1 == 4'd0) begin
                            data_q <= mem[req_idx];
                            done_q <= 1'b1;
                        end else begin
                            idx_q   <= req_idx;
                            cnt_q   <= LAT_M1;
                            state_q <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    if (flush) begin
                        // Abandon the fetch; data_q keeps its old value.
                        cnt_q   <= 4'd0;
                        state_q <= IDLE;
                    end else if (cnt_q == 4'd1) begin
                        data_q  <= mem[idx_q];
                        done_q  <= 1'b1;
                        cnt_q   <= 4'd0;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_fetch_responder.sv
// Self-checking bench for imem_fetch_responder (WORDS_LOG2=9, LAT=3).
// A cycle-indexed model predicts every output on every falling edge. Directed
// literal checks pin the model to hand-computed values.
// Honours IMEM_ALIGN_CHECK_EN the same way the design does.

module tb_imem_fetch_responder;

    localparam int WL  = 9;
    localparam int LAT = 3;
`ifdef IMEM_ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic [15:0] addr;
    logic        flush;
    logic        wr_en;
    logic [15:0] wr_addr;
    logic [15:0] wr_data;
    logic        stall;
    logic        done;
    logic [15:0] data_out;
    logic        err;

    int n_checks = 0;
    int n_fail   = 0;

    imem_fetch_responder #(.WORDS_LOG2(WL), .LAT(LAT)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .addr     (addr),
        .flush    (flush),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .stall    (stall),
        .done     (done),
        .data_out (data_out),
        .err      (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // A pending fetch is described by the absolute cycle its done is due in.
    int          cyc = 0;
    bit          pend = 1'b0;
    int          due  = 0;
    int          pidx = 0;
    logic [15:0] mmem [0:(1<<WL)-1];
    logic        m_done = 1'b0;
    logic        m_err  = 1'b0;
    logic [15:0] m_data = 16'h0000;
    logic        nd, ne;

    always @(posedge clk) begin
        if (!rst) begin
            pend   = 1'b0;
            m_done = 1'b0;
            m_err  = 1'b0;
            m_data = 16'h0000;
        end else begin
            nd = 1'b0;
            ne = 1'b0;
            if (pend) begin
                if (flush) begin
                    pend = 1'b0;
                end else if (cyc + 1 == due) begin
                    m_data = mmem[pidx];
                    nd     = 1'b1;
                    pend   = 1'b0;
                end
            end else if (req && !flush) begin
                if (ALIGN && addr[0]) begin
                    nd = 1'b1; ne = 1'b1; m_data = 16'h0000;
                end else if (LAT == 1) begin
                    m_data = mmem[addr[WL:1]]; nd = 1'b1;
                end else begin
                    pend = 1'b1; due = cyc + LAT; pidx = int'(addr[WL:1]);
                end
            end
            if (wr_en) mmem[wr_addr[WL:1]] = wr_data;
            m_done = nd;
            m_err  = ne;
        end
        cyc++;
    end

    // Per-cycle comparison, away from the active edge.
    always @(negedge clk) begin
        check("stall",    16'(stall),  16'(rst && (pend || (req && !flush))));
        check("done",     16'(done),   16'(rst && m_done && !flush));
        check("err",      16'(err),    16'(rst && m_err && !flush));
        check("data_out", data_out,    rst ? m_data : 16'h0000);
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic neg();
        @(negedge clk);
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; req = 1'b0; addr = 16'h0; flush = 1'b0;
        wr_en = 1'b0; wr_addr = 16'h0; wr_data = 16'h0;
        #1;
        // Reset held with a request present: everything quiet.
        rst = 1'b0; req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            neg();
            check("rst_stall", 16'(stall), 16'h0);
            check("rst_done",  16'(done),  16'h0);
            check("rst_data",  data_out,   16'h0000);
            check("rst_err",   16'(err),   16'h0);
        end
        tick();
        rst = 1'b1; req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            neg();
            check("post_rst_done", 16'(done), 16'h0);
            tick();
        end

        // Program load.
        wr(16'h0004, 16'h1234);
        wr(16'h0000, 16'hAAAA);
        wr(16'h0002, 16'h5555);

        // Single fetch: stall T..T+2, done at T+3 only.
        req = 1'b1; addr = 16'h0004;
        neg(); check("single_stall_T", 16'(stall), 16'h1);
        tick(); req = 1'b0;
        neg(); check("single_stall_T1", 16'(stall), 16'h1);
        check("single_done_T1", 16'(done), 16'h0);
        tick();
        neg(); check("single_stall_T2", 16'(stall), 16'h1);
        tick();
        neg(); check("single_done_T3", 16'(done), 16'h1);
        check("single_data_T3", data_out, 16'h1234);
        check("single_stall_T3", 16'(stall), 16'h0);
        tick();
        neg(); check("single_done_T4", 16'(done), 16'h0);

        // Back-to-back: second request held through the first done cycle.
        tick();
        req = 1'b1; addr = 16'h0000;
        tick(); addr = 16'h0002;
        tick();
        tick();
        neg(); check("b2b_done1", 16'(done), 16'h1);
        check("b2b_data1", data_out, 16'hAAAA);
        check("b2b_stall1", 16'(stall), 16'h1);
        tick(); req = 1'b0;
        tick();
        tick();
        neg(); check("b2b_done2", 16'(done), 16'h1);
        check("b2b_data2", data_out, 16'h5555);
        tick();

        // Flush in BUSY, then idle: stall drops at T+2, no done.
        req = 1'b1; addr = 16'h0004;
        tick(); req = 1'b0; flush = 1'b1;
        tick(); flush = 1'b0;
        neg(); check("flush_stall_T2", 16'(stall), 16'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            neg(); check("flush_no_done", 16'(done), 16'h0);
        end
        tick();

        // Flush then fresh request at T+2: done at T+5 with the new data.
        req = 1'b1; addr = 16'h0004;
        tick(); req = 1'b0; flush = 1'b1;
        tick(); flush = 1'b0; req = 1'b1; addr = 16'h0000;
        tick(); req = 1'b0;
        neg(); check("flush2_done_T3", 16'(done), 16'h0);
        tick();
        tick();
        neg(); check("flush2_done_T5", 16'(done), 16'h1);
        check("flush2_data_T5", data_out, 16'hAAAA);
        tick();

        // Flush in the done cycle masks done but data_out is registered.
        req = 1'b1; addr = 16'h0002;
        tick(); req = 1'b0;
        tick();
        tick(); flush = 1'b1;
        neg(); check("mask_done", 16'(done), 16'h0);
        check("mask_data", data_out, 16'h5555);
        tick(); flush = 1'b0;

        // Alias: 0x0400 lands on word 0.
        wr(16'h0400, 16'hBEEF);
        req = 1'b1; addr = 16'h0000;
        tick(); req = 1'b0;
        tick();
        tick();
        neg(); check("alias_data", data_out, 16'hBEEF);
        tick();

        // Write on the read edge: old data returned.
        req = 1'b1; addr = 16'h0000;
        tick(); req = 1'b0;
        tick(); wr_en = 1'b1; wr_addr = 16'h0000; wr_data = 16'h1111;
        tick(); wr_en = 1'b0;
        neg(); check("race_old_data", data_out, 16'hBEEF);
        tick();
        req = 1'b1; addr = 16'h0000;
        tick(); req = 1'b0;
        tick();
        tick();
        neg(); check("race_new_data", data_out, 16'h1111);
        tick();

        // Write on the edge ending T+LAT-2 is still visible.
        req = 1'b1; addr = 16'h0002;
        tick(); req = 1'b0; wr_en = 1'b1; wr_addr = 16'h0002; wr_data = 16'h2222;
        tick(); wr_en = 1'b0;
        tick();
        neg(); check("late_write_data", data_out, 16'h2222);
        tick();

        // Misaligned request to 0x0003.
        req = 1'b1; addr = 16'h0003;
        tick(); req = 1'b0;
`ifdef IMEM_ALIGN_CHECK_EN
        neg(); check("mis_done", 16'(done), 16'h1);
        check("mis_err", 16'(err), 16'h1);
        check("mis_data", data_out, 16'h0000);
        check("mis_stall", 16'(stall), 16'h0);
`else
        tick();
        tick();
        neg(); check("mis_done", 16'(done), 16'h1);
        check("mis_err", 16'(err), 16'h0);
        check("mis_data", data_out, 16'h2222);
`endif
        tick();
        tick();

        // Reset mid-fetch aborts; nothing follows release.
        req = 1'b1; addr = 16'h0004;
        tick(); req = 1'b0; rst = 1'b0;
        neg(); check("midrst_data", data_out, 16'h0000);
        tick(); rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            neg(); check("midrst_no_done", 16'(done), 16'h0);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
